// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped I/O responder: register offsets,
// control/status bit positions and bus width.
package io_pkg;

  localparam int unsigned DW = 16;

  localparam logic [3:0] OFF_OUT0   = 4'd0;
  localparam logic [3:0] OFF_OUT1   = 4'd1;
  localparam logic [3:0] OFF_IN0    = 4'd2;
  localparam logic [3:0] OFF_IN1    = 4'd3;
  localparam logic [3:0] OFF_TLOAD  = 4'd4;
  localparam logic [3:0] OFF_TCOUNT = 4'd5;
  localparam logic [3:0] OFF_TCTRL  = 4'd6;
  localparam logic [3:0] OFF_ISTAT  = 4'd7;

  localparam int unsigned TC_EN   = 0;
  localparam int unsigned TC_AUTO = 1;
  localparam int unsigned TC_TIE  = 2;
  localparam int unsigned TC_EIE  = 3;

  localparam int unsigned IS_TMR  = 0;
  localparam int unsigned IS_EDGE = 1;

endpackage

// File: rtl/io_timer.sv
// Prescaled down-counting timer: holds TLOAD/TCOUNT and pulses expire_o when a
// tick arrives with the count already at zero.
module io_timer
  import io_pkg::*;
#(
  parameter int unsigned Presc = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          auto_i,
  input  logic          load_we_i,
  input  logic [DW-1:0] load_val_i,
  output logic [DW-1:0] tload_o,
  output logic [DW-1:0] tcount_o,
  output logic          expire_o
);

  localparam int unsigned PW = (Presc > 1) ? $clog2(Presc) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] tload_q, tload_d;
  logic [DW-1:0] count_q, count_d;
  logic          tick;

  assign tick     = en_i && (presc_q == PW'(Presc - 1));
  // A reload write in the same cycle as a tick suppresses that tick's effect.
  assign expire_o = tick && (count_q == '0) && !load_we_i;
  assign tload_o  = tload_q;
  assign tcount_o = count_q;

  always_comb begin
    presc_d = presc_q;
    tload_d = tload_q;
    count_d = count_q;
    if (!en_i || tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
    if (load_we_i) begin
      tload_d = load_val_i;
      count_d = load_val_i;
    end else if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - DW'(1);
      end else if (auto_i) begin
        count_d = tload_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q <= '0;
      tload_q <= '0;
      count_q <= '0;
    end else begin
      presc_q <= presc_d;
      tload_q <= tload_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/io_bus_responder.sv
// Memory-mapped I/O responder on the CPU data bus: 16-word window with output
// ports, synchronised inputs, a timer and an interrupt status register.
module io_bus_responder
  import io_pkg::*;
#(
  parameter logic [15:0] BASE  = 16'hFF00,
  parameter int unsigned PRESC = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          oe,
  input  logic [15:0]   addresses,
  inout  wire  [DW-1:0] data_inout,
  input  logic [DW-1:0] port_in0,
  input  logic [DW-1:0] port_in1,
  output logic [DW-1:0] port_out0,
  output logic [DW-1:0] port_out1,
  output logic [1:0]    irq
);

  logic          sel, wr_en, rd_en;
  logic [3:0]    off;
  logic [DW-1:0] wdata, rdata;

  logic [DW-1:0] out0_q, out0_d, out1_q, out1_d;
  logic [DW-1:0] in0_s1_q, in0_s2_q, in1_s1_q, in1_s2_q;
  logic          in0_prev_q, rise;
  logic [3:0]    tctrl_q, tctrl_d;
  logic [1:0]    istat_q, istat_d;
  logic [1:0]    irq_q, irq_d;
  logic [DW-1:0] tload, tcount;
  logic          expire;

  assign sel   = (addresses[15:4] == BASE[15:4]);
  assign off   = addresses[3:0];
  assign wr_en = oe && sel;
  assign rd_en = !oe && sel;
  assign wdata = data_inout;
  assign rise  = in0_s2_q[0] && !in0_prev_q;

  io_timer #(
    .Presc (PRESC)
  ) u_timer (
    .clk_i      (clk),
    .rst_i      (reset),
    .en_i       (tctrl_q[TC_EN]),
    .auto_i     (tctrl_q[TC_AUTO]),
    .load_we_i  (wr_en && (off == OFF_TLOAD)),
    .load_val_i (wdata),
    .tload_o    (tload),
    .tcount_o   (tcount),
    .expire_o   (expire)
  );

  always_comb begin
    out0_d  = out0_q;
    out1_d  = out1_q;
    tctrl_d = tctrl_q;
    istat_d = istat_q;
    if (expire && !tctrl_q[TC_AUTO]) tctrl_d[TC_EN] = 1'b0;
    if (wr_en) begin
      case (off)
        OFF_OUT0:  out0_d  = wdata;
        OFF_OUT1:  out1_d  = wdata;
        OFF_TCTRL: tctrl_d = wdata[3:0];
        OFF_ISTAT: istat_d = istat_q & ~wdata[1:0];
        default:   ;
      endcase
    end
    // Hardware set is applied after W1C so a same-cycle event is never lost.
    istat_d[IS_TMR]  = istat_d[IS_TMR] | expire;
    istat_d[IS_EDGE] = istat_d[IS_EDGE] | rise;
    irq_d = {istat_q[IS_EDGE] & tctrl_q[TC_EIE], istat_q[IS_TMR] & tctrl_q[TC_TIE]};
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_OUT0:   rdata = out0_q;
      OFF_OUT1:   rdata = out1_q;
      OFF_IN0:    rdata = in0_s2_q;
      OFF_IN1:    rdata = in1_s2_q;
      OFF_TLOAD:  rdata = tload;
      OFF_TCOUNT: rdata = tcount;
      OFF_TCTRL:  rdata = {{(DW-4){1'b0}}, tctrl_q};
      OFF_ISTAT:  rdata = {{(DW-2){1'b0}}, istat_q};
      default:    rdata = '0;
    endcase
  end

  assign data_inout = rd_en ? rdata : {DW{1'bz}};
  assign port_out0  = out0_q;
  assign port_out1  = out1_q;
  assign irq        = irq_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out0_q     <= '0;
      out1_q     <= '0;
      tctrl_q    <= '0;
      istat_q    <= '0;
      irq_q      <= '0;
      in0_s1_q   <= '0;
      in0_s2_q   <= '0;
      in1_s1_q   <= '0;
      in1_s2_q   <= '0;
      in0_prev_q <= 1'b0;
    end else begin
      out0_q     <= out0_d;
      out1_q     <= out1_d;
      tctrl_q    <= tctrl_d;
      istat_q    <= istat_d;
      irq_q      <= irq_d;
      in0_s1_q   <= port_in0;
      in0_s2_q   <= in0_s1_q;
      in1_s1_q   <= port_in1;
      in1_s2_q   <= in1_s1_q;
      in0_prev_q <= in0_s2_q[0];
    end
  end

endmodule

// File: tb/tb_io_bus_responder.sv
// Directed bench for io_bus_responder: bus reads/writes, input sync, timer
// one-shot and auto-reload, W1C race, edge interrupt and mid-count reset.
module tb_io_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        oe;
  logic [15:0] addresses;
  wire  [15:0] data_inout;
  logic        bus_en;
  logic [15:0] bus_drv;
  logic [15:0] port_in0, port_in1;
  logic [15:0] port_out0, port_out1;
  logic [1:0]  irq;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  assign data_inout = bus_en ? bus_drv : 16'hzzzz;

  io_bus_responder #(
    .BASE  (16'hFF00),
    .PRESC (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .oe         (oe),
    .addresses  (addresses),
    .data_inout (data_inout),
    .port_in0   (port_in0),
    .port_in1   (port_in1),
    .port_out0  (port_out0),
    .port_out1  (port_out1),
    .irq        (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input logic [15:0] a, input logic [15:0] exp, input string tag);
    oe        = 1'b0;
    bus_en    = 1'b0;
    addresses = a;
    #2;
    check_eq(tag, {16'h0, data_inout}, {16'h0, exp});
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    oe        = 1'b1;
    bus_en    = 1'b1;
    bus_drv   = d;
    addresses = a;
    step();
    oe        = 1'b0;
    bus_en    = 1'b0;
    addresses = 16'h0000;
  endtask

  initial begin
    reset     = 1'b1;
    oe        = 1'b0;
    bus_en    = 1'b0;
    bus_drv   = 16'h0000;
    addresses = 16'h0000;
    port_in0  = 16'h0000;
    port_in1  = 16'h0000;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    for (int i = 0; i < 16; i++) rd_chk(16'hFF00 | 16'(i), 16'h0000, "rst_rd");
    check_eq("rst_irq", {30'h0, irq}, 32'h0);
    check_eq("rst_out0", {16'h0, port_out0}, 32'h0);
    check_eq("rst_out1", {16'h0, port_out1}, 32'h0);
    step();

    // Port writes, decode window, reserved offsets
    oe = 1'b1; bus_en = 1'b1; bus_drv = 16'hA5A5; addresses = 16'hFF00;
    #2;
    check_eq("out0_pre_edge", {16'h0, port_out0}, 32'h0);
    step();
    oe = 1'b0; bus_en = 1'b0; addresses = 16'h0000;
    check_eq("out0_wr", {16'h0, port_out0}, 32'hA5A5);
    rd_chk(16'hFF00, 16'hA5A5, "out0_rd");
    wr(16'hFF01, 16'h3C3C);
    check_eq("out1_wr", {16'h0, port_out1}, 32'h3C3C);
    wr(16'hFF12, 16'h1111);
    wr(16'h1230, 16'h1111);
    check_eq("out0_outside", {16'h0, port_out0}, 32'hA5A5);
    check_eq("out1_outside", {16'h0, port_out1}, 32'h3C3C);
    wr(16'hFF08, 16'hFFFF);
    rd_chk(16'hFF08, 16'h0000, "reserved_rd");
    // Bench holds the bus at 0; any responder drive would corrupt it.
    oe = 1'b0; bus_en = 1'b1; bus_drv = 16'h0000; addresses = 16'h1230;
    #2;
    check_eq("bus_quiet", {16'h0, data_inout}, 32'h0);
    bus_en = 1'b0;
    step();
    wr(16'hFF06, 16'hFFFF);
    rd_chk(16'hFF06, 16'h000F, "tctrl_mask");
    wr(16'hFF06, 16'h0000);
    wr(16'hFF04, 16'h1234);
    rd_chk(16'hFF04, 16'h1234, "tload_rd");
    rd_chk(16'hFF05, 16'h1234, "tcount_load");

    // Input synchroniser latency
    step();
    port_in1 = 16'h00F0;
    rd_chk(16'hFF03, 16'h0000, "in1_lat0");
    step();
    rd_chk(16'hFF03, 16'h0000, "in1_lat1");
    step();
    rd_chk(16'hFF03, 16'h00F0, "in1_lat2");

    // One-shot timer: TLOAD=3, PRESC=16 -> expiry 64 clocks after EN
    wr(16'hFF04, 16'h0003);
    wr(16'hFF06, 16'h0005);
    repeat (63) step();
    rd_chk(16'hFF07, 16'h0000, "tmr_early");
    step();
    rd_chk(16'hFF07, 16'h0001, "tmr_expire");
    check_eq("tmr_irq_lag", {30'h0, irq}, 32'h0);
    step();
    check_eq("tmr_irq", {30'h0, irq}, 32'h1);
    rd_chk(16'hFF06, 16'h0004, "tmr_en_clr");
    rd_chk(16'hFF05, 16'h0000, "tmr_count0");
    wr(16'hFF07, 16'h0001);
    rd_chk(16'hFF07, 16'h0000, "tmr_w1c");
    step();
    check_eq("tmr_irq_clr", {30'h0, irq}, 32'h0);

    // Auto-reload: TLOAD=1 -> period 32; W1C on the expiry edge loses
    wr(16'hFF04, 16'h0001);
    wr(16'hFF06, 16'h0003);
    repeat (31) step();
    rd_chk(16'hFF07, 16'h0000, "auto_early");
    step();
    rd_chk(16'hFF07, 16'h0001, "auto_exp1");
    rd_chk(16'hFF05, 16'h0001, "auto_reload");
    wr(16'hFF07, 16'h0001);
    rd_chk(16'hFF07, 16'h0000, "auto_w1c");
    repeat (30) step();
    rd_chk(16'hFF07, 16'h0000, "auto_pre2");
    wr(16'hFF07, 16'h0001);
    rd_chk(16'hFF07, 16'h0001, "w1c_race");
    check_eq("auto_irq_off", {30'h0, irq}, 32'h0);
    wr(16'hFF07, 16'h0001);
    rd_chk(16'hFF07, 16'h0000, "w1c_after");
    wr(16'hFF06, 16'h0000);

    // Edge interrupt on IN0[0]
    wr(16'hFF06, 16'h0008);
    port_in0 = 16'h0001;
    step();
    step();
    rd_chk(16'hFF07, 16'h0000, "edge_early");
    step();
    rd_chk(16'hFF07, 16'h0002, "edge_set");
    rd_chk(16'hFF02, 16'h0001, "in0_rd");
    check_eq("edge_irq_lag", {30'h0, irq}, 32'h0);
    step();
    check_eq("edge_irq", {30'h0, irq}, 32'h2);

    // Reset mid-count, colliding with a write
    wr(16'hFF04, 16'h000A);
    wr(16'hFF06, 16'h0003);
    repeat (5) step();
    reset = 1'b1; oe = 1'b1; bus_en = 1'b1; bus_drv = 16'hDEAD; addresses = 16'hFF00;
    step();
    reset = 1'b0; oe = 1'b0; bus_en = 1'b0; addresses = 16'h0000;
    check_eq("mrst_out0", {16'h0, port_out0}, 32'h0);
    check_eq("mrst_out1", {16'h0, port_out1}, 32'h0);
    check_eq("mrst_irq", {30'h0, irq}, 32'h0);
    rd_chk(16'hFF04, 16'h0000, "mrst_tload");
    rd_chk(16'hFF05, 16'h0000, "mrst_tcount");
    rd_chk(16'hFF06, 16'h0000, "mrst_tctrl");
    step();
    rd_chk(16'hFF07, 16'h0000, "mrst_istat");
    rd_chk(16'hFF03, 16'h0000, "mrst_in1");
    repeat (20) step();
    rd_chk(16'hFF05, 16'h0000, "mrst_idle");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/io_bus_responder.md
# io_bus_responder

Memory-mapped I/O responder on the far end of the CPU's external data bus (`addresses`, `data_inout`, `oe`). Decodes a 16-word window, holds two output ports, two synchronised input ports, a prescaled down-counting timer, and an interrupt status register whose lines feed the CPU's `int_e` inputs. Reads are zero-wait and combinational; writes commit on the rising clock edge of the cycle in which the CPU drives the bus.

## Interface
- `BASE`, 16'hFF00: window base; bits [3:0] ignored
- `PRESC`, 16: timer tick every PRESC clocks (≥1)
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `oe`  in  1  CPU bus drive enable; 1 = CPU writing, 0 = CPU reading
- `addresses`  in  16  CPU address (ALU output, valid every cycle)
- `data_inout`  inout  16  shared data bus
- `port_in0`, `port_in1`  in  16 each  asynchronous external inputs
- `port_out0`, `port_out1`  out  16 each  output port registers
- `irq`  out  2  level interrupt requests to `int_e[1:0]`

## Operation
- `sel` = (addresses[15:4] == BASE[15:4]); `off` = addresses[3:0].
- Write: `oe`=1 & `sel` → register at `off` updated at the clock edge. Read: `oe`=0 & `sel` → responder drives `data_inout`; otherwise `data_inout` = 'z. Never drives while `oe`=1.
- Reads have no side effects (address bus toggles every cycle).
- Map (offset: name, access):
  - 0: OUT0 RW → `port_out0`
  - 1: OUT1 RW → `port_out1`
  - 2: IN0 RO, 3: IN1 RO: two-flop synchronised inputs
  - 4: TLOAD RW: reload value; a write also loads TCOUNT
  - 5: TCOUNT RO
  - 6: TCTRL RW: bit0 EN, bit1 AUTO, bit2 TIE (timer irq enable), bit3 EIE (edge irq enable); other bits read 0
  - 7: ISTAT R/W1C: bit0 timer expired, bit1 IN0[0] rising edge (synchronised domain)
  - 8–15: read 0, writes ignored.
- Timer: prescaler counts 0..PRESC-1 while EN=1, `tick` on wrap; prescaler cleared when EN=0. On tick: TCOUNT≠0 → decrement; TCOUNT==0 → set ISTAT[0], then AUTO=1 reloads TLOAD, AUTO=0 clears EN (count stays 0).
- TLOAD write on a tick cycle: load wins over decrement/expiry.
- ISTAT: hardware set and W1C of same bit in one cycle → set wins.
- `irq[0]` = ISTAT[0] & TIE; `irq[1]` = ISTAT[1] & EIE (registered, held until cleared).

## Timing
- Reset: OUT0/OUT1/TLOAD/TCOUNT/TCTRL/ISTAT/prescaler/sync flops = 0; `port_out*`=0, `irq`=0, bus 'z. Reset mid-count aborts it; reset has priority over every write.
- Read data valid combinationally in the same cycle as address.
- Written value visible on `port_out*`/register readback the cycle after the write edge.
- Input path: `port_in*` change visible on IN reads 2 clocks later; IN0[0] rise sets ISTAT[1] 3 clocks after the external edge.
- Timer with TLOAD=N, PRESC=P, EN set at edge t: ISTAT[0] sets at edge t+(N+1)·P; AUTO period (N+1)·P.
- `irq` asserts the cycle after ISTAT bit sets (or after TIE/EIE written with bit already set).

## Structure
- Package `io_pkg`: offset constants (OFF_OUT0..OFF_ISTAT), TCTRL/ISTAT bit indices, data width 16.
- Sub-module `io_timer` (prescaler, TCOUNT, reload/expiry, `expire` pulse); top holds decode, port registers, sync, edge detect, ISTAT, tri-state.

## Test plan
- Reset then read offsets 0–15 with oe=0 → all 0; `irq`=0; bus 'z with address 16'h1234.
- Write 16'hA5A5 to FF00 (oe=1) → `port_out0`=A5A5 next cycle; write to FF12 (outside window) → no change, bus never driven.
- `port_in1`=16'h00F0 → FF03 reads 0 for 2 cycles, then 00F0.
- PRESC=16, TLOAD=3, TCTRL=0b0101 → ISTAT[0] after 64 clocks, `irq[0]`=1 one cycle later, EN cleared; write 1 to FF07 → `irq[0]`=0.
- AUTO=1, TLOAD=1: expiry every 32 clocks; W1C on exact expiry cycle → bit remains 1.
- IN0[0] 0→1 with EIE=1 → ISTAT=0b10, `irq[1]`=1; assert reset mid-count → all registers 0 next edge.
